// File: rtl/cva6_pma_pkg.sv
// Shared types for the runtime-programmable PMA table: attribute/rule payloads,
// the no-match default attribute and the modular region match helper.
package cva6_pma_pkg;

    localparam int unsigned PmaAddrWidth = 56;
    localparam int unsigned MaxPmaRules  = 16;
    localparam int unsigned EpochWidth   = 8;

    typedef struct packed {
        logic cacheable;
        logic nonidem;
        logic exec;
    } pma_attr_t;

    typedef struct packed {
        logic [PmaAddrWidth-1:0] base;
        logic [PmaAddrWidth-1:0] length;
        pma_attr_t               attr;
        logic                    lock;
    } pma_rule_t;

    localparam pma_attr_t PMA_DEFAULT_ATTR = '{cacheable: 1'b0, nonidem: 1'b1, exec: 1'b0};

    // Offset compare wraps modulo 2^PmaAddrWidth, so regions may straddle the top of memory.
    function automatic logic rule_match(input logic [PmaAddrWidth-1:0] addr,
                                        input logic [PmaAddrWidth-1:0] base,
                                        input logic [PmaAddrWidth-1:0] length);
        logic [PmaAddrWidth-1:0] offset;
        offset = addr - base;
        return offset < length;
    endfunction

endpackage

// File: rtl/cva6_pma_table_if.sv
// Configuration port and lookup channels of the PMA table.
// Master drives requests and addresses; slave (the table) returns responses.
interface cva6_pma_table_if
    import cva6_pma_pkg::*;
#(
    parameter int unsigned NrRules   = 4,
    parameter int unsigned NrPorts   = 2,
    parameter int unsigned AddrWidth = PmaAddrWidth
);
    localparam int unsigned IdxW = (NrRules > 1) ? $clog2(NrRules) : 1;

    logic                                cfg_req_i;
    logic                                cfg_we_i;
    logic [IdxW-1:0]                     cfg_idx_i;
    pma_rule_t                           cfg_wdata_i;
    logic                                cfg_gnt_o;
    logic                                cfg_rvalid_o;
    pma_rule_t                           cfg_rdata_o;
    logic                                cfg_err_o;
    logic [EpochWidth-1:0]               cfg_epoch_o;

    logic [NrPorts-1:0]                  lkup_valid_i;
    logic [NrPorts-1:0][AddrWidth-1:0]   lkup_addr_i;
    logic [NrPorts-1:0]                  lkup_valid_o;
    logic [NrPorts-1:0]                  lkup_hit_o;
    pma_attr_t [NrPorts-1:0]             lkup_attr_o;

    modport master (
        output cfg_req_i, cfg_we_i, cfg_idx_i, cfg_wdata_i, lkup_valid_i, lkup_addr_i,
        input  cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o, cfg_err_o, cfg_epoch_o,
               lkup_valid_o, lkup_hit_o, lkup_attr_o
    );

    modport slave (
        input  cfg_req_i, cfg_we_i, cfg_idx_i, cfg_wdata_i, lkup_valid_i, lkup_addr_i,
        output cfg_gnt_o, cfg_rvalid_o, cfg_rdata_o, cfg_err_o, cfg_epoch_o,
               lkup_valid_o, lkup_hit_o, lkup_attr_o
    );

endinterface

// File: rtl/cva6_pma_match.sv
// Combinational priority matcher: the lowest-index rule whose region contains
// the address supplies the attributes; no match yields the default attribute.
module cva6_pma_match
    import cva6_pma_pkg::*;
#(
    parameter int unsigned NrRules = 4
) (
    input  logic [PmaAddrWidth-1:0] i_addr,
    input  pma_rule_t [NrRules-1:0] i_rules,
    output logic                    o_hit_c,
    output pma_attr_t               o_attr_c
);

    logic w_unused_lock;

    // Walk from the highest index down so the lowest matching index is assigned last.
    always_comb begin
        o_hit_c  = 1'b0;
        o_attr_c = PMA_DEFAULT_ATTR;
        for (int i = int'(NrRules) - 1; i >= 0; i--) begin
            if (rule_match(i_addr, i_rules[i].base, i_rules[i].length)) begin
                o_hit_c  = 1'b1;
                o_attr_c = i_rules[i].attr;
            end
        end
    end

    always_comb begin
        w_unused_lock = 1'b0;
        for (int unsigned i = 0; i < NrRules; i++) begin
            w_unused_lock = w_unused_lock ^ i_rules[i].lock;
        end
    end

endmodule

// File: rtl/cva6_pma_table.sv
// Runtime-programmable PMA rule table with one configuration port and NrPorts
// registered lookup channels. Rule locking is built only with CVA6_PMA_LOCK_EN.
module cva6_pma_table
    import cva6_pma_pkg::*;
#(
    parameter int unsigned           NrRules   = 4,
    parameter int unsigned           NrPorts   = 2,
    parameter int unsigned           AddrWidth = PmaAddrWidth,
    parameter pma_rule_t [NrRules-1:0] RstRules = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    cva6_pma_table_if.slave  bus
);

    pma_rule_t [NrRules-1:0]   r_rules;
    logic                      r_rvalid;
    logic                      r_err;
    pma_rule_t                 r_rdata;
    logic [EpochWidth-1:0]     r_epoch;
    logic [NrPorts-1:0]        r_lkup_valid;
    logic [NrPorts-1:0]        r_hit;
    pma_attr_t [NrPorts-1:0]   r_attr;

    logic [NrRules-1:0]        w_sel;
    pma_rule_t                 w_cur;
    pma_rule_t                 w_wdata;
    logic                      w_idx_ok;
    logic                      w_locked;
    logic                      w_wr;
    logic                      w_changed;
    logic [NrPorts-1:0]        w_hit;
    pma_attr_t [NrPorts-1:0]   w_attr;

    // Decode the index without indexing past NrRules when it is not a power of two.
    always_comb begin
        w_sel = '0;
        w_cur = '0;
        for (int unsigned i = 0; i < NrRules; i++) begin
            if (32'(bus.cfg_idx_i) == i) begin
                w_sel[i] = 1'b1;
                w_cur    = r_rules[i];
            end
        end
    end

    assign w_idx_ok = 32'(bus.cfg_idx_i) < NrRules;

`ifdef CVA6_PMA_LOCK_EN
    assign w_locked = w_cur.lock;
    assign w_wdata  = bus.cfg_wdata_i;
`else
    logic w_unused_wlock;
    assign w_unused_wlock = bus.cfg_wdata_i.lock;
    assign w_locked       = 1'b0;
    always_comb begin
        w_wdata      = bus.cfg_wdata_i;
        w_wdata.lock = 1'b0;
    end
`endif

    assign w_wr      = bus.cfg_req_i && bus.cfg_we_i && w_idx_ok && !w_locked;
    assign w_changed = (w_wdata != w_cur);

    for (genvar p = 0; p < int'(NrPorts); p++) begin : g_chan
        cva6_pma_match #(
            .NrRules (NrRules)
        ) u_match (
            .i_addr   (PmaAddrWidth'(bus.lkup_addr_i[p])),
            .i_rules  (r_rules),
            .o_hit_c  (w_hit[p]),
            .o_attr_c (w_attr[p])
        );
    end

    // Rule storage and configuration response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NrRules; i++) begin
                r_rules[i] <= RstRules[i];
`ifndef CVA6_PMA_LOCK_EN
                r_rules[i].lock <= 1'b0;
`endif
            end
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_epoch  <= '0;
        end else begin
            if (w_wr) begin
                for (int unsigned i = 0; i < NrRules; i++) begin
                    if (w_sel[i]) begin
                        r_rules[i] <= w_wdata;
                    end
                end
                if (w_changed) begin
                    r_epoch <= r_epoch + EpochWidth'(1);
                end
            end
            r_rvalid <= bus.cfg_req_i;
            if (bus.cfg_req_i) begin
                r_err   <= !w_idx_ok || (bus.cfg_we_i && w_locked);
                r_rdata <= !w_idx_ok ? '0 : (w_wr ? w_wdata : w_cur);
            end
        end
    end

    // Lookup results hold their last value while a channel is idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_lkup_valid <= '0;
            r_hit        <= '0;
            r_attr       <= '0;
        end else begin
            r_lkup_valid <= bus.lkup_valid_i;
            for (int unsigned p = 0; p < NrPorts; p++) begin
                if (bus.lkup_valid_i[p]) begin
                    r_hit[p]  <= w_hit[p];
                    r_attr[p] <= w_attr[p];
                end
            end
        end
    end

    assign bus.cfg_gnt_o    = bus.cfg_req_i;
    assign bus.cfg_rvalid_o = r_rvalid;
    assign bus.cfg_err_o    = r_err;
    assign bus.cfg_rdata_o  = r_rdata;
    assign bus.cfg_epoch_o  = r_epoch;
    assign bus.lkup_valid_o = r_lkup_valid;
    assign bus.lkup_hit_o   = r_hit;
    assign bus.lkup_attr_o  = r_attr;

endmodule

// File: doc/cva6_pma_table.md
# cva6_pma_table

Runtime-programmable physical memory attribute (PMA) table for CVA6. It replaces the compile-time cached, non-idempotent and execute region rules with `NrRules` rule registers. The registers are reset from parameters and rewritten through a single configuration port. `NrPorts` independent lookup channels (fetch, load/store, PTW) receive registered attribute results. The block sits beside the PMP checker in the MMU/cache-subsystem boundary.

## Interface
- `NrRules`, 4: number of rule entries (1..16).
- `NrPorts`, 2: number of lookup channels (1..4).
- `AddrWidth`, 56: physical address width.
- `RstRules`, all-zero array: per-rule reset value (base, length, attributes, lock).
- `clk_i`  in  1  clock, rising edge.
- `rst_ni`  in  1  reset; one clock; reset is asynchronous and active-low.
- `cfg_req_i`  in  1  configuration access request.
- `cfg_we_i`  in  1  1 = write, 0 = read.
- `cfg_idx_i`  in  $clog2(NrRules)  rule index.
- `cfg_wdata_i`  in  pma_rule_t  rule to write.
- `cfg_gnt_o`  out  1  request accepted; combinationally equals `cfg_req_i`.
- `cfg_rvalid_o`  out  1  response valid, one cycle after grant.
- `cfg_rdata_o`  out  pma_rule_t  read data (rule content after the access).
- `cfg_err_o`  out  1  with `cfg_rvalid_o`: index out of range or write to a locked rule.
- `cfg_epoch_o`  out  8  counts accepted writes that changed state.
- `lkup_valid_i`  in  NrPorts  lookup request per channel.
- `lkup_addr_i`  in  NrPorts×AddrWidth  lookup address.
- `lkup_valid_o`  out  NrPorts  result valid.
- `lkup_hit_o`  out  NrPorts  some rule matched.
- `lkup_attr_o`  out  NrPorts×pma_attr_t  cacheable, non-idempotent, executable.

## Operation
- Rule fields: `base` (AddrWidth), `length` (AddrWidth), `attr`, `lock`.
- Match condition: `(addr - base) < length`, computed modulo 2^AddrWidth.
  - `length == 0` disables the rule.
  - The modular compare makes regions that cross the top of the address space match correctly.
- Priority: the lowest-index matching rule wins.
- No match: `hit = 0`, `attr = {cacheable 0, non-idempotent 1, executable 0}`.
- Configuration write to an unlocked, in-range rule:
  - Rule registers update at the grant edge.
  - `cfg_epoch_o` increments (wraps 255→0) only if the written value differs from the stored value.
- Configuration write to a locked rule: rule unchanged, `cfg_err_o = 1`, epoch unchanged.
- Out-of-range index: `cfg_err_o = 1`, `cfg_rdata_o = 0`, no state change.
- Configuration read: returns the rule; no state change.
- Lock bits are sticky: once set, they clear only by reset.

## Timing
- Reset values:
  - Rules = `RstRules`.
  - `cfg_rvalid_o`, `cfg_err_o`, `cfg_rdata_o`, `cfg_epoch_o`, `lkup_valid_o`, `lkup_hit_o` = 0.
  - `lkup_attr_o` = 0.
- Lookup latency is 1 cycle: `lkup_valid_o[p]` is `lkup_valid_i[p]` registered. Hit and attr registers update only when the input is valid; otherwise they hold.
- Configuration response follows one cycle after the request. Back-to-back requests every cycle are accepted.
- Write and lookup in the same cycle: the lookup uses the pre-write table. The new rule applies from the next cycle's lookup.
- Read and write of the same index in consecutive cycles: the read returns the written value.
- Channels are fully independent; there is no arbitration and no backpressure.
- Reset asserted mid-operation: all state returns to reset values asynchronously and pending responses are dropped.

## Configuration
- `CVA6_PMA_LOCK_EN` defined:
  - Lock field is implemented and enforced.
  - Writing `lock = 1` locks the rule.
- `CVA6_PMA_LOCK_EN` undefined:
  - Lock field is not stored and reads as 0.
  - `RstRules` lock bits are ignored.
  - Writes never produce a lock error.

## Structure
- Package `cva6_pma_pkg` holds:
  - `pma_attr_t` (cacheable, nonidem, exec).
  - `pma_rule_t` (base, length, attr, lock).
  - `PMA_DEFAULT_ATTR` constant.
  - `MaxPmaRules = 16`.
- Sub-module `cva6_pma_match`: combinational priority matcher (address + rule array → hit, attr), instantiated once per channel. The top module owns all registers.

## Test plan
- Reset with `RstRules[0] = {base 0x8000_0000, length 0x4000_0000, cacheable}`.
  - Lookup 0x8000_1000 → next cycle hit = 1, cacheable = 1.
  - Lookup 0x1000 → hit = 0, nonidem = 1.
- Overlap priority:
  - Rule0 = {0x1000, 0x1000, exec}, rule1 = {0x0, 0x10000, nonidem}.
  - Lookup 0x1800 → exec = 1, nonidem = 0. Lookup 0x3000 → nonidem = 1.
- Wrap region: rule = {base 0xFF_FFFF_FFFF_F000, length 0x2000}.
  - 0x0000_0800 hits; 0x0000_1000 misses.
- Same-cycle write and lookup:
  - Write rule0 cacheable = 0 while looking up an address in rule0 → result cacheable = 1.
  - Next lookup → 0. Epoch increases by 1.
  - Identical rewrite → epoch unchanged.
- Lock (macro defined):
  - Write rule2 with lock = 1, then rewrite rule2 → `cfg_err_o = 1`, rule unchanged.
  - Same sequence with macro undefined → no error, rule updated.
- `cfg_idx_i = NrRules` (non-power-of-two `NrRules = 3`) → `cfg_err_o = 1`, `cfg_rdata_o = 0`. Assert `rst_ni` mid-sequence → epoch = 0.
